// File: rtl/sort4_pkg.sv
`default_nettype none
//==============================================================================
// sort4_pkg: shared types and helpers for the 4-input sorter front end.
// Rev 1.0
//==============================================================================
package sort4_pkg;

    localparam int c_width = 16;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        PEND = 1'b1
    } state_t;

    typedef struct packed {
        logic [c_width-1:0] a;
        logic [c_width-1:0] b;
        logic [c_width-1:0] c;
        logic [c_width-1:0] d;
        logic [1:0]         pad_cnt;
    } frame_t;

    // A full frame (count 4) wraps to zero padding.
    function automatic logic [1:0] pad_for(input logic [2:0] cnt);
        logic [2:0] pad;
        pad = 3'd4 - cnt;
        return pad[1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sort4_frame_reg.sv
`default_nettype none
//==============================================================================
// sort4_frame_reg: output holding register presenting one frame to the sorter.
// Rev 1.0
//==============================================================================
module sort4_frame_reg
    import sort4_pkg::*;
#(
    parameter int WIDTH = c_width
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_load,
    input  logic [3:0][WIDTH-1:0]  i_words,
    input  logic [1:0]             i_pad,
    input  logic                   i_frame_ready,
    output logic [WIDTH-1:0]       o_a,
    output logic [WIDTH-1:0]       o_b,
    output logic [WIDTH-1:0]       o_c,
    output logic [WIDTH-1:0]       o_d,
    output logic [1:0]             o_pad_cnt,
    output logic                   o_frame_valid
);

    logic [3:0][WIDTH-1:0] r_words;
    logic [1:0]            r_pad;
    logic                  r_valid;

    // A load on the same edge as an accept keeps valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_words <= '0;
            r_pad   <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_words <= i_words;
            r_pad   <= i_pad;
            r_valid <= 1'b1;
        end else if (i_frame_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_a           = r_words[0];
    assign o_b           = r_words[1];
    assign o_c           = r_words[2];
    assign o_d           = r_words[3];
    assign o_pad_cnt     = r_pad;
    assign o_frame_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/sort4_frame_loader.sv
`default_nettype none
//==============================================================================
// sort4_frame_loader: groups a serial word stream into zero-padded 4-word frames.
// Rev 1.0
//==============================================================================
module sort4_frame_loader
    import sort4_pkg::*;
#(
    parameter int WIDTH = c_width
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic             frame_valid,
    input  logic             frame_ready,
    output logic [1:0]       pad_cnt
);

    state_t                r_state;
    logic [1:0]            r_fill_cnt;
    logic [3:0][WIDTH-1:0] r_buf;
    logic [1:0]            r_pend_pad;

    logic                  w_fill;
    logic                  w_accept;
    logic                  w_out_free;
    logic                  w_close;
    logic                  w_load;
    logic [2:0]            w_cnt_after;
    logic [1:0]            w_pad;
    logic [3:0][WIDTH-1:0] w_words;
    logic [3:0][WIDTH-1:0] w_load_words;
    logic [1:0]            w_load_pad;

    assign w_fill      = (r_state == FILL);
    assign in_ready    = w_fill;
    assign w_accept    = in_valid && w_fill;
    assign w_out_free  = !frame_valid || frame_ready;
    assign w_cnt_after = {1'b0, r_fill_cnt} + {2'b00, w_accept};
    assign w_close     = w_fill && ((w_cnt_after == 3'd4) || (flush && (w_cnt_after != 3'd0)));
    assign w_pad       = pad_for(w_cnt_after);

    // Buffer image after this cycle's word, with slots past the count zeroed.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_slot
            assign w_words[gi] = (3'(gi) >= w_cnt_after)                  ? '0 :
                                 (w_accept && (r_fill_cnt == 2'(gi)))    ? in_data :
                                                                           r_buf[gi];
        end
    endgenerate

    assign w_load       = w_out_free && (w_close || !w_fill);
    assign w_load_words = w_fill ? w_words : r_buf;
    assign w_load_pad   = w_fill ? w_pad   : r_pend_pad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= FILL;
            r_fill_cnt <= '0;
            r_buf      <= '0;
            r_pend_pad <= '0;
        end else if (w_fill) begin
            if (w_accept || w_close) begin
                r_buf <= w_words;
            end
            if (w_close) begin
                r_fill_cnt <= '0;
                r_pend_pad <= w_pad;
                if (!w_out_free) begin
                    r_state <= PEND;
                end
            end else if (w_accept) begin
                r_fill_cnt <= r_fill_cnt + 2'd1;
            end
        end else if (w_out_free) begin
            r_state <= FILL;
        end
    end

    sort4_frame_reg #(
        .WIDTH (WIDTH)
    ) u_frame_reg (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_load        (w_load),
        .i_words       (w_load_words),
        .i_pad         (w_load_pad),
        .i_frame_ready (frame_ready),
        .o_a           (a),
        .o_b           (b),
        .o_c           (c),
        .o_d           (d),
        .o_pad_cnt     (pad_cnt),
        .o_frame_valid (frame_valid)
    );

endmodule
`default_nettype wire
